simple_logic_ff_tester: RTL

SIMPLE_LOGIC_FF_TESTER -- requirements
Module: simple_logic_ff_tester

---
 rtl/simple_logic_ff_tester_if.sv | 54 +++++
 rtl/simple_logic_ff_tester.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/simple_logic_ff_tester_if.sv
// Bundle of the tester's control, status and stimulus/response signals.
//   master : the tester itself (drives stimulus and status, reads start and dut_out)
//   slave  : the environment (drives start and dut_out, observes everything else)
//   start           - level request to begin a run
//   dut_a..dut_d    - registered stimulus towards the device under test
//   dut_out         - response from the device under test
//   busy/done/pass  - run status
//   err_count       - mismatches in the current or last run (saturating)
//   first_err_valid - a mismatch has been recorded this run
//   first_err_vec   - {a,b,c,d} of the first mismatching vector
interface simple_logic_ff_tester_if;
    logic       start;
    logic       dut_a;
    logic       dut_b;
    logic       dut_c;
    logic       dut_d;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic       first_err_valid;
    logic [3:0] first_err_vec;

    modport master (
        input  start,
        input  dut_out,
        output dut_a,
        output dut_b,
        output dut_c,
        output dut_d,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_err_valid,
        output first_err_vec
    );

    modport slave (
        output start,
        output dut_out,
        input  dut_a,
        input  dut_b,
        input  dut_c,
        input  dut_d,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_err_valid,
        input  first_err_vec
    );
endinterface

// File: rtl/simple_logic_ff_tester.sv
// Exhaustive tester for a 4-input logic block computing out = (a|b)&(c|d) with a fixed
// register latency. A run drives all 16 input vectors, one per cycle, and compares each
// response LATENCY cycles later against the expected value carried down a shift pipeline.
//   LATENCY - device input-to-output latency in cycles (legal range 1..4)
//   clk     - single clock, rising edge
//   rst     - asynchronous, active-high reset
//   bus     - tester side of simple_logic_ff_tester_if (see interface header)
module simple_logic_ff_tester #(
    parameter int unsigned LATENCY = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    simple_logic_ff_tester_if.master       bus
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [2:0] DrainLast = 3'(LATENCY - 1);
    localparam logic [4:0] ErrMax    = 5'd31;

    // Control state
    logic [1:0] state_q, state_d;
    logic [3:0] vec_q, vec_d;
    logic [3:0] stim_q, stim_d;
    logic [2:0] drain_cnt_q, drain_cnt_d;

    // Expected-value pipeline; index LATENCY-1 is the tail compared against dut_out
    logic [LATENCY-1:0]      pipe_valid_q, pipe_valid_d;
    logic [LATENCY-1:0]      pipe_exp_q, pipe_exp_d;
    logic [LATENCY-1:0][3:0] pipe_vec_q, pipe_vec_d;

    // Results
    logic [4:0] err_count_q, err_count_d;
    logic       first_err_valid_q, first_err_valid_d;
    logic [3:0] first_err_vec_q, first_err_vec_d;

    logic run_start;
    logic in_run;
    logic active;
    logic tail_valid;
    logic tail_exp;
    logic [3:0] tail_vec;
    logic mismatch;

    function automatic logic expected_of(input logic [3:0] v);
        return (v[3] | v[2]) & (v[1] | v[0]);
    endfunction

    assign in_run    = (state_q == StRun);
    assign active    = (state_q == StRun) || (state_q == StDrain);
    // start is honoured only from IDLE or DONE; it is ignored while busy
    assign run_start = bus.start && ((state_q == StIdle) || (state_q == StDone));

    assign tail_valid = pipe_valid_q[LATENCY-1];
    assign tail_exp   = pipe_exp_q[LATENCY-1];
    assign tail_vec   = pipe_vec_q[LATENCY-1];
    assign mismatch   = active && tail_valid && (bus.dut_out != tail_exp);

    // ------------------------------------------------------------------
    // Sequencing: RUN for 16 vectors, DRAIN for LATENCY cycles, then DONE
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        drain_cnt_d = drain_cnt_q;

        case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = StRun;
                    vec_d   = 4'd0;
                end
            end
            StRun: begin
                vec_d = vec_q + 4'd1;
                if (vec_q == 4'd15) begin
                    state_d     = StDrain;
                    drain_cnt_d = 3'd0;
                end
            end
            StDrain: begin
                drain_cnt_d = drain_cnt_q + 3'd1;
                if (drain_cnt_q == DrainLast) begin
                    state_d = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Stimulus pins are registered so they line up exactly with vec during RUN
        stim_d = (state_d == StRun) ? vec_d : 4'd0;
    end

    // ------------------------------------------------------------------
    // Expected-value pipeline: advances every cycle, loads valid only in RUN
    // ------------------------------------------------------------------
    always_comb begin
        pipe_valid_d    = '0;
        pipe_exp_d      = '0;
        pipe_vec_d      = '0;

        pipe_valid_d[0] = in_run;
        pipe_exp_d[0]   = expected_of(stim_q);
        pipe_vec_d[0]   = stim_q;
        for (int i = 1; i < int'(LATENCY); i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_exp_d[i]   = pipe_exp_q[i-1];
            pipe_vec_d[i]   = pipe_vec_q[i-1];
        end

        if (run_start) begin
            pipe_valid_d = '0;
            pipe_exp_d   = '0;
            pipe_vec_d   = '0;
        end
    end

    // ------------------------------------------------------------------
    // Result accumulation
    // ------------------------------------------------------------------
    always_comb begin
        err_count_d       = err_count_q;
        first_err_valid_d = first_err_valid_q;
        first_err_vec_d   = first_err_vec_q;

        if (run_start) begin
            err_count_d       = 5'd0;
            first_err_valid_d = 1'b0;
            first_err_vec_d   = 4'd0;
        end else if (mismatch) begin
            if (err_count_q != ErrMax) begin
                err_count_d = err_count_q + 5'd1;
            end
            // Only the first mismatch of a run is captured
            if (!first_err_valid_q) begin
                first_err_valid_d = 1'b1;
                first_err_vec_d   = tail_vec;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= StIdle;
            vec_q             <= 4'd0;
            stim_q            <= 4'd0;
            drain_cnt_q       <= 3'd0;
            pipe_valid_q      <= '0;
            pipe_exp_q        <= '0;
            pipe_vec_q        <= '0;
            err_count_q       <= 5'd0;
            first_err_valid_q <= 1'b0;
            first_err_vec_q   <= 4'd0;
        end else begin
            state_q           <= state_d;
            vec_q             <= vec_d;
            stim_q            <= stim_d;
            drain_cnt_q       <= drain_cnt_d;
            pipe_valid_q      <= pipe_valid_d;
            pipe_exp_q        <= pipe_exp_d;
            pipe_vec_q        <= pipe_vec_d;
            err_count_q       <= err_count_d;
            first_err_valid_q <= first_err_valid_d;
            first_err_vec_q   <= first_err_vec_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.dut_a           = stim_q[3];
    assign bus.dut_b           = stim_q[2];
    assign bus.dut_c           = stim_q[1];
    assign bus.dut_d           = stim_q[0];
    assign bus.busy            = active;
    assign bus.done            = (state_q == StDone);
    assign bus.pass            = (state_q == StDone) && (err_count_q == 5'd0);
    assign bus.err_count       = err_count_q;
    assign bus.first_err_valid = first_err_valid_q;
    assign bus.first_err_vec   = first_err_vec_q;

endmodule
